// File: rtl/riscv_aes_wb_pkg.sv
// riscv_aes_wb_pkg: shared types and widths for the AES result write-back scheduler
package riscv_aes_wb_pkg;
  typedef enum logic {IDLE, WRITE} state_t;
  localparam int NUM_BEATS = 4;
  localparam int BEAT_W = 32;
  localparam int BLK_W = 128;
  typedef struct packed {
    logic [31:0] addr;
    logic [BLK_W-1:0] data;
  } aes_wb_entry_t;
endpackage

// File: rtl/riscv_aes_wb_fifo.sv
// riscv_aes_wb_fifo: synchronous queue of AES result entries; head is read from registered storage
module riscv_aes_wb_fifo
  import riscv_aes_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  aes_wb_entry_t i_din,
  output aes_wb_entry_t o_head,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH):0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  aes_wb_entry_t r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  assign o_head = r_mem[r_rptr[AW-1:0]];
  assign o_cnt = r_wptr - r_rptr;
  assign o_full = o_cnt == (AW+1)'(DEPTH);
  assign o_empty = o_cnt == '0;
endmodule

// File: rtl/riscv_aes_wb_sched.sv
// riscv_aes_wb_sched: queues AES result blocks and drains each as four 32-bit write beats.
// Define RISCV_AES_WB_BSWAP_EN to byte-reverse each beat word (AES big-endian to RISC-V little-endian).
module riscv_aes_wb_sched
  import riscv_aes_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wb_valid_i,
  output logic wb_ready_o,
  input  logic [31:0] wb_addr_i,
  input  logic [BLK_W-1:0] wb_data_i,
  output logic mem_req_o,
  input  logic mem_gnt_i,
  output logic mem_we_o,
  output logic [3:0] mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  output logic halt_en_o,
  output logic busy_o,
  output logic done_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t r_state;
  logic [1:0] r_beat;
  aes_wb_entry_t w_din, w_head;
  logic w_full, w_empty, w_push, w_fire, w_last;
  logic [CW-1:0] w_cnt;
  logic [31:0] w_addr;
  logic [BEAT_W-1:0] w_word, w_data;
  assign w_din = '{addr: wb_addr_i, data: wb_data_i};
  assign w_push = wb_valid_i && !w_full;
  assign w_fire = mem_req_o && mem_gnt_i;
  assign w_last = w_fire && r_beat == 2'(NUM_BEATS - 1);
  riscv_aes_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_push),
    .i_pop(w_last),
    .i_din(w_din),
    .o_head(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_cnt(w_cnt)
  );
  // Entering WRITE on the push edge itself gives req in the very next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat <= '0;
    end else if (r_state == IDLE) begin
      r_state <= (w_push || !w_empty) ? WRITE : IDLE;
      r_beat <= '0;
    end else if (w_fire) begin
      r_beat <= r_beat + 2'd1;
      r_state <= (w_last && w_cnt == CW'(1) && !w_push) ? IDLE : WRITE;
    end
  end
  assign w_addr = (w_head.addr & ~32'd3) + {28'd0, r_beat, 2'b00};
  assign w_word = w_head.data[{r_beat, 5'd0} +: BEAT_W];
`ifdef RISCV_AES_WB_BSWAP_EN
  assign w_data = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
`else
  assign w_data = w_word;
`endif
  assign mem_req_o = r_state == WRITE;
  assign mem_we_o = mem_req_o;
  assign mem_be_o = {4{mem_req_o}};
  assign mem_addr_o = mem_req_o ? w_addr : '0;
  assign mem_wdata_o = mem_req_o ? w_data : '0;
  assign wb_ready_o = !w_full;
  assign halt_en_o = wb_valid_i && !wb_ready_o;
  assign busy_o = !w_empty || r_state != IDLE;
  assign done_o = w_last;
endmodule

// File: tb/tb_riscv_aes_wb_sched.sv
// tb_riscv_aes_wb_sched: queue-level model compared every cycle plus directed literal checks
module tb_riscv_aes_wb_sched;
  localparam int DEPTH = 2;
  typedef struct {
    logic [31:0] a;
    logic [127:0] d;
  } ent_t;
  logic clk = 0, rst_n = 0, wb_valid_i = 0, mem_gnt_i = 0;
  logic [31:0] wb_addr_i = 0;
  logic [127:0] wb_data_i = 0;
  logic wb_ready_o, mem_req_o, mem_we_o, halt_en_o, busy_o, done_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  int total = 0, bad = 0, k = 0, nd = 0, n1004 = 0;
  bit mon = 0;
  ent_t mq[$];
  logic [31:0] la[$], ld[$];

  riscv_aes_wb_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .halt_en_o(halt_en_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sw(logic [31:0] w);
`ifdef RISCV_AES_WB_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit pu;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      k = 0;
      mon = 1;
    end else begin
      pu = wb_valid_i && mq.size() < DEPTH;
      e.a = wb_addr_i;
      e.d = wb_data_i;
      if (mq.size() > 0 && mem_gnt_i) begin
        if (k == 3) begin
          void'(mq.pop_front());
          k = 0;
        end else k++;
      end
      if (pu) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    bit er;
    logic [31:0] ea, ed;
    if (mon) begin
      er = mq.size() > 0;
      ea = er ? (mq[0].a & ~32'd3) + 32'(4 * k) : 32'd0;
      ed = er ? sw(mq[0].d[32*k +: 32]) : 32'd0;
      chk("req", 32'(mem_req_o), 32'(er));
      chk("we", 32'(mem_we_o), 32'(er));
      chk("be", 32'(mem_be_o), er ? 32'hF : 32'h0);
      chk("addr", mem_addr_o, ea);
      chk("wdata", mem_wdata_o, ed);
      chk("ready", 32'(wb_ready_o), 32'(mq.size() < DEPTH));
      chk("halt", 32'(halt_en_o), 32'(wb_valid_i && mq.size() >= DEPTH));
      chk("busy", 32'(busy_o), 32'(er));
      chk("done", 32'(done_o), 32'(er && mem_gnt_i && k == 3));
      if (mem_req_o && mem_gnt_i) begin
        la.push_back(mem_addr_o);
        ld.push_back(mem_wdata_o);
      end
      if (done_o) nd++;
      if (mem_req_o && mem_addr_o == 32'h1004) n1004++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] a, logic [127:0] d);
    wb_valid_i = 1;
    wb_addr_i = a;
    wb_data_i = d;
    step();
    wb_valid_i = 0;
  endtask

  task automatic clr();
    la.delete();
    ld.delete();
    nd = 0;
    n1004 = 0;
  endtask

  localparam logic [127:0] BLK = 128'h44444444_33333333_22222222_11111111;

  initial begin
    int w;
    repeat (2) step();
    rst_n = 1;
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_ready", 32'(wb_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    // 1: continuous grant
    clr();
    mem_gnt_i = 1;
    step();
    push(32'h1000, BLK);
    repeat (5) step();
    chk("t1_n", la.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", la[i], 32'h1000 + 32'(4 * i));
      chk("t1_data", ld[i], sw(32'h11111111 * 32'(i + 1)));
    end
    chk("t1_done", nd, 1);
    chk("t1_busy", 32'(busy_o), 0);
    // 2: beat 1 stalled three cycles
    clr();
    mem_gnt_i = 0;
    push(32'h1000, BLK);
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    repeat (3) step();
    mem_gnt_i = 1;
    repeat (5) step();
    chk("t2_n", la.size(), 4);
    chk("t2_hold", n1004, 4);
    chk("t2_a1", la[1], 32'h1004);
    chk("t2_a3", la[3], 32'h100C);
    // 3: overflow and back-to-back drain
    clr();
    mem_gnt_i = 0;
    for (int b = 0; b < 2; b++)
      push(32'h2000 + 32'(16 * b), {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)});
    wb_valid_i = 1;
    wb_addr_i = 32'h2020;
    wb_data_i = {32'd11, 32'd10, 32'd9, 32'd8};
    @(negedge clk);
    chk("t3_halt", 32'(halt_en_o), 1);
    chk("t3_ready", 32'(wb_ready_o), 0);
    step();
    mem_gnt_i = 1;
    w = 0;
    while (!wb_ready_o && w < 20) begin
      step();
      w++;
    end
    chk("t3_accept_to", 32'(w < 20), 1);
    step();
    wb_valid_i = 0;
    repeat (14) step();
    chk("t3_n", la.size(), 12);
    chk("t3_done", nd, 3);
    for (int i = 0; i < 12 && i < la.size(); i++) begin
      chk("t3_addr", la[i], 32'h2000 + 32'(4 * i));
      chk("t3_data", ld[i], sw(32'(i)));
    end
    // 4: address wrap and misaligned base
    clr();
    push(32'hFFFFFFF8, BLK);
    repeat (5) step();
    chk("t4_a0", la[0], 32'hFFFFFFF8);
    chk("t4_a1", la[1], 32'hFFFFFFFC);
    chk("t4_a2", la[2], 32'h00000000);
    chk("t4_a3", la[3], 32'h00000004);
    clr();
    push(32'h1003, BLK);
    repeat (5) step();
    chk("t4_mis", la[0], 32'h1000);
    // 5: reset in mid-block
    clr();
    mem_gnt_i = 0;
    push(32'h4000, BLK);
    mem_gnt_i = 1;
    repeat (2) step();
    mem_gnt_i = 0;
    chk("t5_pre", la.size(), 2);
    rst_n = 0;
    step();
    rst_n = 1;
    mem_gnt_i = 1;
    chk("t5_req", 32'(mem_req_o), 0);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_ready", 32'(wb_ready_o), 1);
    repeat (5) step();
    chk("t5_n", la.size(), 2);
`ifdef RISCV_AES_WB_BSWAP_EN
    // 6: byte swap
    clr();
    push(32'h3000, {96'd0, 32'h11223344});
    repeat (5) step();
    chk("t6_swap", ld[0], 32'h44332211);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
